ysyx_22040365_ifu: RTL and testbench

- Instruction fetch unit, directly upstream of the decode stage.
- Holds the architectural PC and issues one fetch request at a time to instruction memory over a valid/ready request channel.
- Captures the 32-bit response and presents inst/pc to decode behind a valid/ready handshake.
- Accepts a redirect (jump/branch target) from execute at any time; squashes any fetch already in flight.

---
 rtl/ysyx_22040365_ifu_pkg.sv | 16 +
 rtl/ysyx_22040365_pc_reg.sv | 30 +++
 rtl/ysyx_22040365_ifu.sv | 126 ++++++++++++
 tb/tb_ysyx_22040365_ifu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ysyx_22040365_ifu_pkg;

  localparam int          IFU_PC_W     = 64;
  localparam int          IFU_INST_W   = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IFU_INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ysyx_22040365_pc_reg.sv
// Architectural PC register: redirect target beats +4, which beats hold.
// Next value visible one cycle after load/inc; never stalls.
module ysyx_22040365_pc_reg
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_r
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= target & ALIGN_MASK;
    end else if (inc) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Fetch unit: one outstanding imem request, response buffered to decode; id_valid N+k+1 after accept.
// Decode backpressure holds inst/pc in S_HOLD and blocks the next request; redirects squash in-flight fetches.
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INST_W   = IFU_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  ifu_state_t      state, state_n;
  logic            drop, drop_n;
  logic            fresh;
  logic [PC_W-1:0] pc_r;
  logic            pc_inc;
  logic            req_hs;
  logic            take_rsp;

  assign imem_req_valid = rst && (state == S_REQ);
  assign imem_req_addr  = pc_r & ALIGN_MASK;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign pc_inc         = (state == S_HOLD) && id_ready;
  assign take_rsp       = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;

  ysyx_22040365_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (redirect_valid),
    .inc    (pc_inc),
    .target (redirect_pc),
    .pc_r   (pc_r)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    drop_n  = drop;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ:  if (imem_req_ready) state_n = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_n = drop ? S_REQ : S_HOLD;
          drop_n  = 1'b0;
        end
      end
      S_HOLD: if (id_ready) state_n = S_REQ;
      default: state_n = S_IDLE;
    endcase

    // A redirect overrides everything; drop tracks whether a stale response is still owed.
    if (redirect_valid) begin
      case (state)
        S_REQ: begin
          state_n = imem_req_ready ? S_WAIT : S_REQ;
          drop_n  = imem_req_ready;
        end
        S_WAIT: begin
          state_n = imem_rsp_valid ? S_REQ : S_WAIT;
          drop_n  = !imem_rsp_valid;
        end
        default: begin
          state_n = S_REQ;
          drop_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid <= 1'b0;
      inst     <= '0;
      pc       <= RESET_PC;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
    end else if (take_rsp) begin
      id_valid <= 1'b1;
      inst     <= imem_rsp_data;
      pc       <= pc_r;
    end else if (pc_inc) begin
      id_valid <= 1'b0;
    end
  end

  // Until the first post-reset request is accepted, a late response for a pre-reset request is tolerated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fresh <= 1'b1;
    end else if (req_hs) begin
      fresh <= 1'b0;
    end
  end

  rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (state == S_WAIT || fresh));

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Directed bench for the fetch unit with a latency-programmable instruction memory model.
module tb_ysyx_22040365_ifu;
  import ysyx_22040365_ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  ysyx_22040365_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .inst           (inst),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // memory model state
  int          mem_lat = 1;
  bit          pend    = 0;
  int          cnt     = 0;
  logic [63:0] paddr   = '0;
  int          n_acc   = 0;

  typedef struct {
    logic [63:0] addr;
    int          lat;
    int          rdy_wait;
    int          hold;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[3];

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    return {a[21:2], 12'h013};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: note a request handshake before the edge, then advance the memory model.
  task automatic step();
    bit hs;
    logic [63:0] a;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    if (hs) n_acc++;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (hs) begin
      pend  = 1;
      cnt   = mem_lat;
      paddr = a;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(paddr);
        pend           = 0;
      end
    end
  endtask

  task automatic wait_id(input string name, input int lat);
    int t;
    t = 0;
    while (!id_valid && t < 20) begin
      step();
      t++;
    end
    check({name, "_id_valid"}, 64'(id_valid), 64'd1);
    check({name, "_latency"}, 64'(t), 64'(lat));
  endtask

  // From S_REQ: accept immediately, then expect the delivered pc/inst.
  task automatic do_fetch(input string name, input logic [63:0] a, input int lat, input logic [31:0] ei);
    mem_lat = lat;
    check({name, "_req_valid"}, 64'(imem_req_valid), 64'd1);
    check({name, "_req_addr"}, imem_req_addr, a);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    wait_id(name, lat);
    check({name, "_pc"}, pc, a);
    check({name, "_inst"}, 64'(inst), 64'(ei));
  endtask

  task automatic consume();
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
  endtask

  // Step until a new request shows up, recording whether decode ever saw a valid.
  task automatic wait_req(input string name, input logic [63:0] a);
    int t;
    bit saw;
    t = 0;
    saw = 0;
    while (!imem_req_valid && t < 20) begin
      saw |= id_valid;
      step();
      t++;
    end
    saw |= id_valid;
    check({name, "_no_stale_id"}, 64'(saw), 64'd0);
    check({name, "_req_valid"}, 64'(imem_req_valid), 64'd1);
    check({name, "_req_addr"}, imem_req_addr, a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;

    vecs[0] = '{addr: 64'h8000_0000, lat: 1, rdy_wait: 0, hold: 0, inst: 32'h0010_0093};
    vecs[1] = '{addr: 64'h8000_0004, lat: 1, rdy_wait: 3, hold: 5, inst: 32'h0000_1013};
    vecs[2] = '{addr: 64'h8000_0008, lat: 3, rdy_wait: 1, hold: 2, inst: 32'h0000_2013};

    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = IFU_INST_NOP;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    repeat (3) step();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_pc", pc, 64'h8000_0000);

    rst = 1'b1;
    check("idle_req_valid", 64'(imem_req_valid), 64'd0);
    step();

    // Sequential fetches with request stalls and decode backpressure.
    for (int i = 0; i < 3; i++) begin
      mem_lat = vecs[i].lat;
      check($sformatf("v%0d_req_valid", i), 64'(imem_req_valid), 64'd1);
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].addr);
      for (int w = 0; w < vecs[i].rdy_wait; w++) begin
        step();
        check($sformatf("v%0d_stall_valid", i), 64'(imem_req_valid), 64'd1);
        check($sformatf("v%0d_stall_addr", i), imem_req_addr, vecs[i].addr);
      end
      acc0 = n_acc;
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      check($sformatf("v%0d_one_accept", i), 64'(n_acc - acc0), 64'd1);
      check($sformatf("v%0d_wait_no_req", i), 64'(imem_req_valid), 64'd0);
      wait_id($sformatf("v%0d", i), vecs[i].lat);
      check($sformatf("v%0d_inst", i), 64'(inst), 64'(vecs[i].inst));
      check($sformatf("v%0d_pc", i), pc, vecs[i].addr);
      for (int h = 0; h < vecs[i].hold; h++) begin
        step();
        check($sformatf("v%0d_hold_valid", i), 64'(id_valid), 64'd1);
        check($sformatf("v%0d_hold_inst", i), 64'(inst), 64'(vecs[i].inst));
        check($sformatf("v%0d_hold_pc", i), pc, vecs[i].addr);
        check($sformatf("v%0d_hold_no_req", i), 64'(imem_req_valid), 64'd0);
      end
      consume();
      check($sformatf("v%0d_consumed", i), 64'(id_valid), 64'd0);
      check($sformatf("v%0d_resume", i), 64'(imem_req_valid), 64'd1);
    end

    // Redirect while waiting on a 3-cycle response: that response is discarded.
    mem_lat = 3;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    step();
    redirect_valid = 1'b0;
    check("rw_still_waiting", 64'(imem_req_valid), 64'd0);
    wait_req("rw", 64'h8000_0100);
    do_fetch("rw_fetch", 64'h8000_0100, 1, 32'h0004_0013);

    // Redirect coinciding with the decode handshake: target wins over pc+4.
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    step();
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    check("rh_id_valid", 64'(id_valid), 64'd0);
    check("rh_req_valid", 64'(imem_req_valid), 64'd1);
    check("rh_req_addr", imem_req_addr, 64'h8000_1000);

    // Redirect coinciding with the request handshake: that request's response is dropped.
    mem_lat        = 2;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    wait_req("rq", 64'h8000_2000);
    do_fetch("rq_fetch", 64'h8000_2000, 1, 32'h0080_0013);
    consume();

    // Reset while waiting; the orphaned response lands in the first cycle after release.
    check("rs_pre_addr", imem_req_addr, 64'h8000_2004);
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    pend           = 0;
    rst            = 1'b0;
    step();
    step();
    check("rs_in_reset_req", 64'(imem_req_valid), 64'd0);
    check("rs_in_reset_id", 64'(id_valid), 64'd0);
    check("rs_in_reset_pc", pc, 64'h8000_0000);
    rst            = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    check("rs_idle_req", 64'(imem_req_valid), 64'd0);
    step();
    check("rs_no_spurious_id", 64'(id_valid), 64'd0);
    do_fetch("rs_fetch", 64'h8000_0000, 1, 32'h0010_0093);
    consume();
    check("rs_next_addr", imem_req_addr, 64'h8000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
